// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a raster-scanned feature map.
// All CH channels travel in parallel; one pooled position is emitted per
// completed 2x2 window, on the same edge that accepts its bottom-right pixel.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting at (0,0) for the first beat of a frame
// S_ACTIVE | frame in progress; the (IN_H-1, IN_W-1) beat fires done
module maxpool_2x2_stream #(
    parameter int DATA_W = 16,
    parameter int CH     = 4,
    parameter int IN_W   = 14,
    parameter int IN_H   = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] pixel_in  [0:CH-1],
    input  logic                     valid_in,
    output logic signed [DATA_W-1:0] pixel_out [0:CH-1],
    output logic                     valid_out,
    output logic                     done
);

    localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int LB_D  = (IN_W / 2 > 0) ? IN_W / 2 : 1;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    generate
        if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_in_w
            $error("maxpool_2x2_stream: IN_W must be even and >= 2");
        end
        if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_in_h
            $error("maxpool_2x2_stream: IN_H must be even and >= 2");
        end
    endgenerate

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       w_done_nxt;
    logic                       r_done;

    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_row;
    logic                       w_last_col;
    logic                       w_last_row;
    logic                       w_col_odd;
    logic                       w_row_odd;
    logic [LB_AW-1:0]           w_lidx;

    logic signed [DATA_W-1:0]   r_hreg      [0:CH-1];
    logic signed [DATA_W-1:0]   r_lbuf      [0:LB_D-1][0:CH-1];
    logic signed [DATA_W-1:0]   w_hmax      [0:CH-1];
    logic signed [DATA_W-1:0]   w_vmax      [0:CH-1];
    logic signed [DATA_W-1:0]   r_pixel_out [0:CH-1];
    logic                       r_valid_out;

    assign w_last_col = (r_col == COL_W'(IN_W - 1));
    assign w_last_row = (r_row == ROW_W'(IN_H - 1));
    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_lidx     = LB_AW'(r_col >> 1);

    // Raster position counters; they move only on accepted beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_in) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Frame FSM state register and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Frame FSM next state: done fires on the final beat of the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (valid_in && w_last_col && w_last_row) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Horizontal pair max, then vertical max against the stored upper row.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_hmax[c] = (pixel_in[c] > r_hreg[c]) ? pixel_in[c] : r_hreg[c];
            w_vmax[c] = (w_hmax[c] > r_lbuf[w_lidx][c]) ? w_hmax[c] : r_lbuf[w_lidx][c];
        end
    end

    // Left pixel of each horizontal pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                r_hreg[c] <= '0;
            end
        end else if (valid_in && !w_col_odd) begin
            for (int c = 0; c < CH; c++) begin
                r_hreg[c] <= pixel_in[c];
            end
        end
    end

    // Line buffer: no reset needed, every entry is rewritten on an even row before use.
    always_ff @(posedge clk) begin
        if (valid_in && w_col_odd && !w_row_odd) begin
            for (int c = 0; c < CH; c++) begin
                r_lbuf[w_lidx][c] <= w_hmax[c];
            end
        end
    end

    // Output register: loads on each bottom-right window pixel, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                r_pixel_out[c] <= '0;
            end
        end else begin
            r_valid_out <= 1'b0;
            if (valid_in && w_col_odd && w_row_odd) begin
                r_valid_out <= 1'b1;
                for (int c = 0; c < CH; c++) begin
                    r_pixel_out[c] <= w_vmax[c];
                end
            end
        end
    end

    assign pixel_out = r_pixel_out;
    assign valid_out = r_valid_out;
    assign done      = r_done;

endmodule
